bcd_to_bin_seq: RTL and testbench

//   Sequential packed-BCD to unsigned binary converter (reverse double-dabble).

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_adjust.sv | 20 ++
 rtl/bcd_to_bin_seq.sv | 132 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD to binary converter.
//   - BCD digit geometry and legality limit
//   - reverse double-dabble adjust threshold/value
//   - converter FSM state encoding
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_MAX_DIGIT  = 9;
  localparam int BCD_ADJ_THRESH = 8;
  localparam int BCD_ADJ_VAL    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A BCD digit is illegal when it encodes a value above 9 (codes A..F).
  function automatic logic digit_illegal(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step of reverse double-dabble.
//   d : digit value after the right shift
//   q : d - 3 when d >= 8, otherwise d unchanged
// The subtract is a plain 4-bit one; a digit >= 8 always yields 5..12,
// so no borrow ever leaves the digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      q = d - BCD_DIGIT_W'(BCD_ADJ_VAL);
    end
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// One binary bit is resolved per clock; BIN_W steps per legal word.
//
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   in_valid    : in_bcd holds a word to convert
//   in_ready    : converter idle; a word is accepted on in_valid && in_ready
//   in_bcd      : packed BCD, digit 0 in [3:0]
//   out_valid   : out_bin/out_err hold a result
//   out_ready   : consumer takes the result on out_valid && out_ready
//   out_bin     : binary result (0 when out_err)
//   out_err     : some input digit was > 9
//   state_dbg   : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Upstream keeps in_valid/in_bcd stable until accepted; the
// result stays stable while out_valid is high and out_ready is low.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIN_W-1:0]          out_bin,
  output logic                      out_err,
  output state_t                    state_dbg
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;

  logic [SR_W-1:0]   shifted;
  logic [SR_W-1:0]   stepped;
  logic              in_illegal;

  // One conversion step: shift the whole {bcd,bin} register right, then
  // correct every BCD digit of the shifted value.
  assign shifted = sr_q >> 1;
  assign stepped[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d(shifted[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .q(stepped[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    in_illegal = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_illegal(in_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
        in_illegal = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sr_d  = {in_bcd, {BIN_W{1'b0}}};
          cnt_d = '0;
          if (in_illegal) begin
            // Illegal words skip conversion and report straight away.
            state_d = ST_DONE;
            bin_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        sr_d  = stepped;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = ST_DONE;
          bin_d   = stepped[BIN_W-1:0];
          err_d   = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_bin   = bin_q;
  assign out_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: default instance (2 digits, 7 bits) and a
// 3-digit / 10-bit instance. Expected results come from a decimal
// reference model that reads the BCD digits with plain arithmetic.
module tb_bcd_to_bin_seq;
  import bcd_pkg::*;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int W      = BIN_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, out_valid, out_ready, out_err;
  logic [7:0]       in_bcd;
  logic [BIN_W-1:0] out_bin;
  state_t           state_dbg;

  logic             in_valid2, in_ready2, out_valid2, out_ready2, out_err2;
  logic [11:0]      in_bcd2;
  logic [9:0]       out_bin2;
  state_t           state_dbg2;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_err(out_err), .state_dbg(state_dbg)
  );

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_bcd(in_bcd2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_bin(out_bin2), .out_err(out_err2), .state_dbg(state_dbg2)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic void ref_model(input int nd, input logic [31:0] b,
                                    output int v, output bit e);
    int m, d;
    v = 0; e = 0; m = 1;
    for (int i = 0; i < nd; i++) begin
      d = int'((b >> (4 * i)) & 32'hF);
      if (d > 9) e = 1;
      v = v + d * m;
      m = m * 10;
    end
    if (e) v = 0;
  endfunction

  function automatic logic [W-1:0] expect_word(input logic [7:0] b);
    int v; bit e;
    ref_model(DIGITS, {24'b0, b}, v, e);
    return {e, v[BIN_W-1:0]};
  endfunction

  function automatic logic [7:0] rand_legal();
    logic [3:0] hi, lo;
    hi = 4'($urandom_range(0, 9));
    lo = 4'($urandom_range(0, 9));
    return {hi, lo};
  endfunction

  // ---------------- driver: one full transaction ----------------
  task automatic convert(input logic [7:0] b, input int stall, input string name);
    int k;
    logic [W-1:0] exp;
    @(negedge clk);
    in_valid = 1'b1; in_bcd = b; out_ready = (stall == 0);
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL %s accept: in_ready=%0b required 1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    exp = expect_word(b);
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_bcd = 8'($urandom);  // ignored after acceptance
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (k !== (exp[BIN_W] ? 0 : BIN_W)) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, required %0d", name, k, exp[BIN_W] ? 0 : BIN_W);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {out_err, out_bin} !== exp) begin
        errors++;
        $display("FAIL %s stall: valid=%0b res=%h required valid=1 res=%h", name, out_valid, {out_err, out_bin}, exp);
      end
    end
    out_ready = 1'b1;
    checks++;
    exp = exp_q.pop_front();
    if ({out_err, out_bin} !== exp) begin
      errors++;
      $display("FAIL %s result: bcd=%h got err=%0b bin=%0d required err=%0b bin=%0d",
               name, b, out_err, out_bin, exp[BIN_W], exp[BIN_W-1:0]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    in_valid = 0; in_bcd = 8'h99; out_ready = 0;
    in_valid2 = 0; in_bcd2 = 12'h0; out_ready2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bin !== '0 || out_err !== 1'b0 ||
        state_dbg !== ST_IDLE || in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%0b vld=%0b bin=%0d err=%0b st=%0d rdy2=%0b vld2=%0b required 1 0 0 0 0 1 0",
               in_ready, out_valid, out_bin, out_err, state_dbg, in_ready2, out_valid2);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    convert(8'h00, 0, "zero");
    convert(8'h99, 0, "max99");
    convert(8'h47, 0, "v47");
    convert(8'h10, 0, "v10");
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 100; i++) begin
      logic [3:0] hi, lo;
      hi = 4'(i / 10); lo = 4'(i % 10);
      convert({hi, lo}, 0, "sweep");
    end
  endtask

  task automatic test_error();
    convert(8'h3A, 0, "err3A");
    convert(8'h25, 0, "after_err");
    convert(8'hF0, 1, "errF0");
    convert(8'h9B, 0, "err9B");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    int k;
    @(negedge clk);
    in_valid = 1'b1; in_bcd = 8'h58; out_ready = 1'b0;
    exp = expect_word(8'h58);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_err, out_bin} !== exp) begin
        errors++;
        $display("FAIL backpressure hold: vld=%0b rdy=%0b res=%h required 1 0 %h",
                 out_valid, in_ready, {out_err, out_bin}, exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int c, last_acc, nacc;
    logic [W-1:0] exp;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_bcd = rand_legal();
    last_acc = -1; nacc = 0; c = 0;
    while (c < 200 && nacc < 6) begin
      if (out_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({out_err, out_bin} !== exp) begin
          errors++;
          $display("FAIL b2b result: got %h required %h", {out_err, out_bin}, exp);
        end
      end
      if (in_ready) begin
        exp_q.push_back(expect_word(in_bcd));
        if (last_acc >= 0) begin
          checks++;
          if (c - last_acc != BIN_W + 2) begin
            errors++;
            $display("FAIL b2b spacing: got %0d required %0d", c - last_acc, BIN_W + 2);
          end
        end
        last_acc = c; nacc++;
      end else begin
        in_bcd = rand_legal();  // changes during CONV must not matter
      end
      @(negedge clk); c++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
      if (out_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({out_err, out_bin} !== exp) begin
          errors++;
          $display("FAIL b2b drain: got %h required %h", {out_err, out_bin}, exp);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || nacc != 6) begin
      errors++;
      $display("FAIL b2b count: pending=%0d accepts=%0d required 0 6", exp_q.size(), nacc);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_bcd = 8'h77; out_ready = 1'b1;
    @(posedge clk);            // accept
    repeat (3) @(posedge clk); // three steps done
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state_dbg !== ST_IDLE || out_valid !== 1'b0 || in_ready !== 1'b1 || out_bin !== '0) begin
      errors++;
      $display("FAIL reset_mid: st=%0d vld=%0b rdy=%0b bin=%0d required 0 0 1 0",
               state_dbg, out_valid, in_ready, out_bin);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid emit: out_valid cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rand_legal();
      convert(b, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_param();
    logic [11:0] codes[4];
    codes[0] = 12'h999; codes[1] = 12'h512; codes[2] = 12'h000; codes[3] = 12'h4C1;
    for (int i = 0; i < 8; i++) begin
      logic [11:0] b;
      int v, k; bit e;
      if (i < 4) b = codes[i];
      else b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ref_model(3, {20'b0, b}, v, e);
      @(negedge clk);
      in_valid2 = 1'b1; in_bcd2 = b; out_ready2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid2 = 1'b0;
      k = 0;
      while (!out_valid2 && k < 50) begin @(negedge clk); k++; end
      checks++;
      if (out_valid2 !== 1'b1 || k != (e ? 0 : 10) || out_err2 !== e || out_bin2 !== 10'(v)) begin
        errors++;
        $display("FAIL param3 %h: vld=%0b lat=%0d err=%0b bin=%0d required 1 %0d %0b %0d",
                 b, out_valid2, k, out_err2, out_bin2, e ? 0 : 10, e, v);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_error();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
